// File: rtl/ryu_anim_controller.sv
// ryu_anim_controller: vsync-paced fighter sprite animation sequencer (idle/walk/punch/kick) with ROM base address.
// Optional RYU_ANIM_PAUSE_EN adds a pause input that discards vsync ticks.
module ryu_anim_controller #(
  parameter int HOLD_FRAMES     = 6,
  parameter int IDLE_FRAMES     = 4,
  parameter int WALK_FRAMES     = 5,
  parameter int PUNCH_FRAMES    = 3,
  parameter int KICK_FRAMES     = 5,
  parameter int PUNCH_HIT_FRAME = 1,
  parameter int KICK_HIT_FRAME  = 2,
  parameter int FRAME_WORDS     = 5310,
  parameter int ADDR_W          = 17
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              vsync,
`ifdef RYU_ANIM_PAUSE_EN
  input  logic              pause,
`endif
  input  logic              punch,
  input  logic              kick,
  input  logic              left,
  input  logic              right,
  output logic [1:0]        state,
  output logic [2:0]        frame_idx,
  output logic [ADDR_W-1:0] rom_base,
  output logic              facing_left,
  output logic              hit_active,
  output logic              busy,
  output logic              anim_done
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WALK  = 2'd1;
  localparam logic [1:0] S_PUNCH = 2'd2;
  localparam logic [1:0] S_KICK  = 2'd3;
  localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [2:0] IDLE_LAST  = 3'(IDLE_FRAMES - 1);
  localparam logic [2:0] WALK_LAST  = 3'(WALK_FRAMES - 1);
  localparam logic [2:0] PUNCH_LAST = 3'(PUNCH_FRAMES - 1);
  localparam logic [2:0] KICK_LAST  = 3'(KICK_FRAMES - 1);
  localparam logic [2:0] PUNCH_HIT  = 3'(PUNCH_HIT_FRAME);
  localparam logic [2:0] KICK_HIT   = 3'(KICK_HIT_FRAME);
  localparam logic [ADDR_W-1:0] BASE_WALK  = ADDR_W'(IDLE_FRAMES);
  localparam logic [ADDR_W-1:0] BASE_PUNCH = ADDR_W'(IDLE_FRAMES + WALK_FRAMES);
  localparam logic [ADDR_W-1:0] BASE_KICK  = ADDR_W'(IDLE_FRAMES + WALK_FRAMES + PUNCH_FRAMES);

  logic              vsync_q;
  logic              tick;
  logic              walk_req;
  logic              hold_end;
  logic              at_last;
  logic [HW-1:0]     hold_cnt;
  logic [HW-1:0]     hold_nx;
  logic [1:0]        state_nx;
  logic [2:0]        frame_nx;
  logic [2:0]        last;
  logic              face_nx;
  logic              done_nx;
  logic [ADDR_W-1:0] seq_base;

  // vsync_q tracks vsync even while paused so a release mid-pulse cannot fake an edge
`ifdef RYU_ANIM_PAUSE_EN
  assign tick = vsync & ~vsync_q & ~pause;
`else
  assign tick = vsync & ~vsync_q;
`endif
  assign walk_req   = left ^ right;
  assign busy       = state[1];
  assign hit_active = (state == S_PUNCH && frame_idx == PUNCH_HIT) || (state == S_KICK && frame_idx == KICK_HIT);
  assign hold_end   = hold_cnt == HW'(HOLD_FRAMES - 1);
  assign last       = state == S_IDLE ? IDLE_LAST : state == S_WALK ? WALK_LAST : state == S_PUNCH ? PUNCH_LAST : KICK_LAST;
  assign at_last    = frame_idx == last;
  assign seq_base   = state == S_IDLE ? '0 : state == S_WALK ? BASE_WALK : state == S_PUNCH ? BASE_PUNCH : BASE_KICK;

  always_comb begin
    state_nx = state;
    frame_nx = frame_idx;
    hold_nx  = hold_cnt;
    face_nx  = facing_left;
    done_nx  = 1'b0;
    if (tick) begin
      hold_nx = hold_end ? '0 : hold_cnt + 1'b1;
      if (hold_end)
        frame_nx = at_last ? 3'd0 : frame_idx + 3'd1;
      if (busy) begin
        if (hold_end && at_last) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end else begin
        face_nx = (left & ~right) ? 1'b1 : (right & ~left) ? 1'b0 : facing_left;
        // a request that differs from the current loop restarts the sequence at frame 0
        if (punch | kick | (walk_req != (state == S_WALK))) begin
          state_nx = punch ? S_PUNCH : kick ? S_KICK : walk_req ? S_WALK : S_IDLE;
          frame_nx = 3'd0;
          hold_nx  = '0;
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vsync_q     <= 1'b0;
      state       <= S_IDLE;
      frame_idx   <= 3'd0;
      hold_cnt    <= '0;
      facing_left <= 1'b0;
      anim_done   <= 1'b0;
      rom_base    <= '0;
    end else begin
      vsync_q     <= vsync;
      state       <= state_nx;
      frame_idx   <= frame_nx;
      hold_cnt    <= hold_nx;
      facing_left <= face_nx;
      anim_done   <= done_nx;
      rom_base    <= (seq_base + ADDR_W'(frame_idx)) * ADDR_W'(FRAME_WORDS);
    end
  end
endmodule

// File: tb/tb_ryu_anim_controller.sv
// tb_ryu_anim_controller: scoreboard bench driving vsync pulses against a tick-level reference model.
module tb_ryu_anim_controller;
  logic        vga_clk, reset, vsync, pause, punch, kick, left, right;
  logic [1:0]  state;
  logic [2:0]  frame_idx;
  logic [16:0] rom_base;
  logic        facing_left, hit_active, busy, anim_done;

  typedef struct { int st; int fr; int rom; int face; int hit; int bsy; int dn; } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, done_seen = 0;
  int m_st = 0, m_fr = 0, m_hold = 0, m_face = 0;
  int base_tbl[4] = '{0, 4, 9, 12};

  ryu_anim_controller dut (
    .vga_clk(vga_clk), .reset(reset), .vsync(vsync),
`ifdef RYU_ANIM_PAUSE_EN
    .pause(pause),
`endif
    .punch(punch), .kick(kick), .left(left), .right(right),
    .state(state), .frame_idx(frame_idx), .rom_base(rom_base), .facing_left(facing_left),
    .hit_active(hit_active), .busy(busy), .anim_done(anim_done)
  );

  initial vga_clk = 0;
  always #5 vga_clk = ~vga_clk;
  always @(negedge vga_clk) if (anim_done === 1'b1) done_seen++;

  task automatic model_reset();
    m_st = 0; m_fr = 0; m_hold = 0; m_face = 0;
  endtask

  task automatic model_tick(output int dn);
    int n;
    dn = 0;
    n = m_st == 0 ? 4 : m_st == 1 ? 5 : m_st == 2 ? 3 : 5;
    if (m_st < 2) begin
      if (left && !right) m_face = 1;
      else if (right && !left) m_face = 0;
      if (punch) begin m_st = 2; m_fr = 0; m_hold = 0; return; end
      if (kick) begin m_st = 3; m_fr = 0; m_hold = 0; return; end
      if ((left != right) && m_st == 0) begin m_st = 1; m_fr = 0; m_hold = 0; return; end
      if ((left == right) && m_st == 1) begin m_st = 0; m_fr = 0; m_hold = 0; return; end
    end
    m_hold++;
    if (m_hold == 6) begin
      m_hold = 0;
      m_fr++;
      if (m_fr == n) begin
        m_fr = 0;
        if (m_st >= 2) begin m_st = 0; dn = 1; end
      end
    end
  endtask

  // one vsync pulse; expectation queued before driving, popped and compared once outputs settle
  task automatic pulse(input bit do_tick);
    exp_t e, g;
    int dn, d0;
    dn = 0;
    if (do_tick) model_tick(dn);
    e.st = m_st; e.fr = m_fr; e.rom = (base_tbl[m_st] + m_fr) * 5310; e.face = m_face;
    e.hit = ((m_st == 2 && m_fr == 1) || (m_st == 3 && m_fr == 2)) ? 1 : 0;
    e.bsy = m_st >= 2 ? 1 : 0; e.dn = dn;
    sb.push_back(e);
    d0 = done_seen;
    vsync = 1;
    repeat (3) @(negedge vga_clk);
    vsync = 0;
    repeat (2) @(negedge vga_clk);
    g = sb.pop_front();
    tests += 7;
    if (state !== 2'(g.st)) begin fails++; $display("FAIL state got=%0d exp=%0d", state, g.st); end
    if (frame_idx !== 3'(g.fr)) begin fails++; $display("FAIL frame_idx got=%0d exp=%0d", frame_idx, g.fr); end
    if (rom_base !== 17'(g.rom)) begin fails++; $display("FAIL rom_base got=%0d exp=%0d", rom_base, g.rom); end
    if (facing_left !== 1'(g.face)) begin fails++; $display("FAIL facing_left got=%0b exp=%0d", facing_left, g.face); end
    if (hit_active !== 1'(g.hit)) begin fails++; $display("FAIL hit_active got=%0b exp=%0d st=%0d fr=%0d", hit_active, g.hit, g.st, g.fr); end
    if (busy !== 1'(g.bsy)) begin fails++; $display("FAIL busy got=%0b exp=%0d", busy, g.bsy); end
    if (done_seen - d0 != g.dn) begin fails++; $display("FAIL anim_done pulses got=%0d exp=%0d", done_seen - d0, g.dn); end
  endtask

  task automatic apply_reset();
    reset = 1; vsync = 0; punch = 0; kick = 0; left = 0; right = 0; pause = 0;
    repeat (2) @(negedge vga_clk);
    reset = 0;
    model_reset();
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    reset = 1; vsync = 0; punch = 0; kick = 0; left = 0; right = 0; pause = 0;
    repeat (3) @(negedge vga_clk);
    tests += 4;
    if (state !== 2'd0 || frame_idx !== 3'd0) begin fails++; $display("FAIL reset_state got=%0d/%0d exp=0/0", state, frame_idx); end
    if (rom_base !== 17'd0) begin fails++; $display("FAIL reset_rom got=%0d exp=0", rom_base); end
    if (facing_left !== 1'b0 || hit_active !== 1'b0) begin fails++; $display("FAIL reset_face_hit got=%0b%0b exp=00", facing_left, hit_active); end
    if (busy !== 1'b0 || anim_done !== 1'b0) begin fails++; $display("FAIL reset_busy_done got=%0b%0b exp=00", busy, anim_done); end
    reset = 0;
    model_reset();
    @(negedge vga_clk);
  endtask

  task automatic test_idle();
    repeat (24) pulse(1);
  endtask

  task automatic test_walk();
    right = 1;
    repeat (6) pulse(1);
    right = 0;
    pulse(1);
  endtask

  task automatic test_punch();
    int g = 0;
    punch = 1;
    repeat (3) pulse(1);
    punch = 0;
    while (m_st != 0 && g < 40) begin pulse(1); g++; end
    tests++;
    if (g >= 40) begin fails++; $display("FAIL punch_end got=timeout exp=idle"); end
  endtask

  task automatic test_kick();
    int g = 0;
    left = 1; right = 1;
    pulse(1);
    left = 0; right = 0; kick = 1;
    pulse(1);
    kick = 0;
    while (m_st != 0 && g < 40) begin
      punch = (g % 7 == 3); left = (g % 5 == 1);
      pulse(1);
      g++;
    end
    punch = 0; left = 0;
    tests++;
    if (g >= 40) begin fails++; $display("FAIL kick_end got=timeout exp=idle"); end
  endtask

  task automatic test_both_dirs();
    right = 1; pulse(1); right = 0; pulse(1);
    left = 1; right = 1;
    repeat (3) pulse(1);
    right = 0;
    repeat (2) pulse(1);
    left = 0;
    pulse(1);
  endtask

  task automatic test_back_to_back();
    int g = 0;
    punch = 1;
    repeat (22) pulse(1);
    punch = 0;
    while (m_st != 0 && g < 40) begin pulse(1); g++; end
    tests++;
    if (g >= 40) begin fails++; $display("FAIL b2b_end got=timeout exp=idle"); end
  endtask

  task automatic test_reset_mid_kick();
    int g = 0, d0;
    kick = 1; pulse(1); kick = 0;
    while (!(m_st == 3 && m_fr == 3) && g < 40) begin pulse(1); g++; end
    d0 = done_seen;
    vsync = 1; reset = 1;
    @(negedge vga_clk);
    tests += 3;
    if (state !== 2'd0 || frame_idx !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL midkick_reset_state got=%0d/%0d/%0b exp=0/0/0", state, frame_idx, busy); end
    if (rom_base !== 17'd0 || hit_active !== 1'b0 || facing_left !== 1'b0) begin fails++; $display("FAIL midkick_reset_out got=%0d/%0b/%0b exp=0/0/0", rom_base, hit_active, facing_left); end
    reset = 0; vsync = 0;
    model_reset();
    repeat (3) @(negedge vga_clk);
    if (done_seen != d0 || anim_done !== 1'b0) begin fails++; $display("FAIL midkick_done got=%0d exp=0", done_seen - d0); end
    pulse(1);
  endtask

`ifdef RYU_ANIM_PAUSE_EN
  task automatic test_pause();
    apply_reset();
    repeat (5) pulse(1);
    pause = 1;
    repeat (10) pulse(0);
    vsync = 1;
    repeat (2) @(negedge vga_clk);
    pause = 0;
    repeat (2) @(negedge vga_clk);
    vsync = 0;
    repeat (2) @(negedge vga_clk);
    pulse(1);
    pulse(1);
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_walk();
    test_punch();
    test_kick();
    test_both_dirs();
    test_back_to_back();
    test_reset_mid_kick();
`ifdef RYU_ANIM_PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ryu_anim_controller.md
Name: ryu_anim_controller

Overview:
- Sequences animation frames for the fighter sprite renderer. Chooses an action (idle, walk, punch, kick) from player inputs.
- Advances the frame once per HOLD_FRAMES vertical syncs and outputs the sprite-sheet base word address the renderer adds to its in-sprite ROM offset.
- Also produces the facing direction, an attack hit window, and an end-of-attack pulse for game logic.
- Sits between keyboard/game logic and the sprite draw module, in the vga_clk domain.

Parameters:
- HOLD_FRAMES, 6, vsync periods each animation frame is held (>=1)
- IDLE_FRAMES, 4, frames in idle loop
- WALK_FRAMES, 5, frames in walk loop
- PUNCH_FRAMES, 3, frames in punch sequence (>=2)
- KICK_FRAMES, 5, frames in kick sequence (>=2)
- PUNCH_HIT_FRAME, 1, punch frame index with hit_active high
- KICK_HIT_FRAME, 2, kick frame index with hit_active high
- FRAME_WORDS, 5310, ROM words per frame (59x90)
- ADDR_W, 17, width of rom_base

Ports:
- vga_clk  in  1  pixel clock, all logic on posedge
- reset  in  1  synchronous, active-high
- vsync  in  1  VGA vertical sync level, synchronous to vga_clk
- punch  in  1  punch request (level)
- kick  in  1  kick request (level)
- left  in  1  move-left request (level)
- right  in  1  move-right request (level)
- state  out  2  0=IDLE 1=WALK 2=PUNCH 3=KICK
- frame_idx  out  3  frame within current sequence
- rom_base  out  ADDR_W  first ROM word of current frame
- facing_left  out  1  1 = sprite mirrored to face left
- hit_active  out  1  attack hit window
- busy  out  1  high in PUNCH or KICK
- anim_done  out  1  one-cycle pulse when an attack finishes

Behaviour:
- Reset values: state=IDLE, frame_idx=0, hold_cnt=0, rom_base=0, facing_left=0, hit_active=0, busy=0, anim_done=0, vsync_q=0.
- Tick: tick = vsync & ~vsync_q, with vsync_q registered. Tick is the only event that changes state, frame_idx or facing. The first vsync high after reset produces a tick.
- Walk request: walk_req = left ^ right. Both held or neither held means no walk.
- On a tick in IDLE or WALK, requests are sampled with priority punch > kick > walk_req > none.
  - punch: go to PUNCH, frame_idx=0, hold_cnt=0.
  - kick: go to KICK, frame_idx=0, hold_cnt=0.
  - walk_req while in IDLE: go to WALK, frame 0, hold_cnt=0. If already in WALK, stay and advance normally.
  - no request while in WALK: go to IDLE, frame 0, hold_cnt=0. If already in IDLE, advance normally.
  - facing_left updates on the same tick: set if left&~right, cleared if right&~left, otherwise held. Never updates in PUNCH or KICK.
- Normal advance on a tick:
  - If hold_cnt < HOLD_FRAMES-1, increment hold_cnt.
  - Otherwise hold_cnt=0 and frame_idx advances.
  - IDLE and WALK wrap frame_idx from N-1 to 0.
- Attacks cannot be interrupted; punch, kick, left and right are ignored while busy.
  - On advance past the last frame: state=IDLE, frame_idx=0, anim_done=1 for exactly one vga_clk.
  - Requests are not sampled on that same tick; the earliest re-trigger is the next tick.
- hit_active = (state==PUNCH && frame_idx==PUNCH_HIT_FRAME) || (state==KICK && frame_idx==KICK_HIT_FRAME).
- busy is decoded from state.
- rom_base is registered: (seq_base + frame_idx) * FRAME_WORDS.
  - seq_base is 0 for IDLE, IDLE_FRAMES for WALK, IDLE_FRAMES+WALK_FRAMES for PUNCH, and IDLE_FRAMES+WALK_FRAMES+PUNCH_FRAMES for KICK.
  - Latency is 1 vga_clk after the state/frame_idx update, so rom_base settles during vertical blanking.
  - Width: the product is computed at ADDR_W bits. With defaults the maximum is 16*5310 = 84960, which fits in 17 bits.
- Reset asserted together with a tick, or mid-attack: reset wins and no anim_done is produced.

Optional Feature:
- Macro RYU_ANIM_PAUSE_EN adds input port pause (1 bit).
- With the macro defined: while pause=1, ticks are discarded (hold_cnt, state, frame_idx and facing are frozen, and requests are not sampled). vsync_q keeps tracking vsync, so releasing pause mid-vsync-high produces no spurious tick. Outputs hold their values.
- Without the macro: the port is absent and the behaviour is exactly as above.

Test Plan:
- Reset, no inputs, 24 vsync pulses -> state=0; frame_idx steps 0,1,2,3,0 every 6 ticks; rom_base=0,5310,10620,15930,0.
- Hold right for 6 ticks, then release -> state=1 on the first tick, rom_base=21240, facing_left=0. On the first tick after release: state=0, frame_idx=0.
- punch held from IDLE -> PUNCH. hit_active high exactly while frame_idx=1 (ticks 7-12). After 18 ticks: anim_done single pulse, state=0, rom_base=0.
- kick pressed, then punch and left pulsed mid-kick -> kick runs all 5 frames (30 ticks). rom_base for frame 4 = 16*5310 = 84960. facing_left unchanged.
- left & right both held from IDLE -> no walk, facing unchanged. Then left only -> WALK, facing_left=1.
- reset asserted at kick frame 3 coincident with a tick -> next cycle all outputs at reset values, anim_done=0. With RYU_ANIM_PAUSE_EN: pause=1 for 10 vsyncs -> frame_idx unchanged.
